// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM encoding and GF(2^8) helpers.
// Used by the round controller and its combinational round datapath.
package aes_pkg;

  localparam int NR = 10;
  localparam int NK = 4;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] POLY      = 8'h1b;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } st_e;

  function automatic logic [7:0] xtime(
    input logic [7:0] a
  );
    return {a[6:0], 1'b0} ^ (a[7] ? POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse as a^254 via the chain a^3, a^7 .. a^127, then one square.
  // Zero maps to zero, as the S-box requires.
  function automatic logic [7:0] ginv(
    input logic [7:0] a
  );
    logic [7:0] r;
    r = a;
    for (int i = 0; i < 6; i++) begin
      r = gmul(gmul(r, r), a);
    end
    return gmul(r, r);
  endfunction

  function automatic logic [7:0] sbox(
    input logic [7:0] a
  );
    logic [7:0] b;
    b = ginv(a);
    return b
      ^ {b[6:0], b[7]}
      ^ {b[5:0], b[7:6]}
      ^ {b[4:0], b[7:5]}
      ^ {b[3:0], b[7:4]}
      ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(
    input logic [31:0] w
  );
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < NK; i++) begin
      r[31-8*i -: 8] = sbox(w[31-8*i -: 8]);
    end
    return r;
  endfunction

  function automatic logic [31:0] rot_word(
    input logic [31:0] w
  );
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes128_round_fn.sv
// One combinational AES round: SubBytes, ShiftRows, MixColumns, AddRoundKey.
// Ports: i_state, i_rkey, i_final (drop MixColumns) in; o_state out.
import aes_pkg::*;

module aes128_round_fn (
  input  logic [127:0] i_state,
  input  logic [127:0] i_rkey,
  input  logic         i_final,
  output logic [127:0] o_state
);

  logic [127:0] w_sb;
  logic [127:0] w_sr;
  logic [127:0] w_mc;

  // Byte (row r, col c) sits at index r+4c; row r rotates left by r.
  for (genvar c = 0; c < 4; c++) begin : g_c
    for (genvar r = 0; r < 4; r++) begin : g_r
      localparam int D = r + 4*c;
      localparam int S = r + 4*((c + r) % 4);

      assign w_sb[127-8*D -: 8] = sbox(i_state[127-8*D -: 8]);
      assign w_sr[127-8*D -: 8] = w_sb[127-8*S -: 8];
    end
  end

  aes_mix_columns u_mix (
    .i_state (w_sr),
    .o_state (w_mc)
  );

  assign o_state = (i_final ? w_sr : w_mc) ^ i_rkey;

endmodule

// File: rtl/aes_mix_columns.sv
// MixColumns over a full 128-bit column-major AES state.
// Ports: i_state in, o_state out (both byte 0 in [127:120]).
import aes_pkg::*;

module aes_mix_columns (
  input  logic [127:0] i_state,
  output logic [127:0] o_state
);

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] w_a0;
    logic [7:0] w_a1;
    logic [7:0] w_a2;
    logic [7:0] w_a3;

    assign w_a0 = i_state[127-32*c -: 8];
    assign w_a1 = i_state[119-32*c -: 8];
    assign w_a2 = i_state[111-32*c -: 8];
    assign w_a3 = i_state[103-32*c -: 8];

    assign o_state[127-32*c -: 8] =
      xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
    assign o_state[119-32*c -: 8] =
      w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
    assign o_state[111-32*c -: 8] =
      w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
    assign o_state[103-32*c -: 8] =
      xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
  end

endmodule

// File: rtl/aes128_round_ctrl.sv
// Iterative AES-128 encryption controller: one round and one key step per cycle.
// Ports: CLK, RST (sync, active-high); IN_valid/IN_ready/IN_data/IN_key input
// handshake; OUT_valid/OUT_ready/OUT_data output handshake; OUT_round debug.
import aes_pkg::*;

module aes128_round_ctrl #(
  parameter int ROUNDS = 10
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         IN_valid,
  output logic         IN_ready,
  input  logic [127:0] IN_data,
  input  logic [127:0] IN_key,
  output logic         OUT_valid,
  input  logic         OUT_ready,
  output logic [127:0] OUT_data,
  output logic [3:0]   OUT_round
);

  if (ROUNDS != NR) begin : g_rounds_chk
    $error("aes128_round_ctrl: only ROUNDS=10 is supported");
  end

  st_e          r_st;
  logic [127:0] r_state;
  logic [127:0] r_key;
  logic [7:0]   r_rcon;
  logic [3:0]   r_rnd;
  logic         r_in_rdy;
  logic         r_out_vld;

  logic [31:0]  w_t;
  logic [31:0]  w_w0;
  logic [31:0]  w_w1;
  logic [31:0]  w_w2;
  logic [31:0]  w_w3;
  logic [127:0] w_nk;
  logic [127:0] w_rnd_out;
  logic         w_final;

  // Next round key from the current one, word 3 feeding the g() step.
  always_comb begin
    w_t  = sub_word(rot_word(r_key[31:0])) ^ {r_rcon, 24'h000000};
    w_w0 = r_key[127:96] ^ w_t;
    w_w1 = r_key[95:64]  ^ w_w0;
    w_w2 = r_key[63:32]  ^ w_w1;
    w_w3 = r_key[31:0]   ^ w_w2;
    w_nk = {w_w0, w_w1, w_w2, w_w3};
  end

  assign w_final = (r_rnd == 4'(ROUNDS));

  aes128_round_fn u_round (
    .i_state (r_state),
    .i_rkey  (w_nk),
    .i_final (w_final),
    .o_state (w_rnd_out)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_st      <= S_IDLE;
      r_state   <= '0;
      r_key     <= '0;
      r_rcon    <= RCON_INIT;
      r_rnd     <= '0;
      r_in_rdy  <= 1'b1;
      r_out_vld <= 1'b0;
    end else begin
      unique case (r_st)
        S_IDLE: begin
          if (IN_valid) begin
            r_state  <= IN_data ^ IN_key;
            r_key    <= IN_key;
            r_rcon   <= RCON_INIT;
            r_rnd    <= 4'd1;
            r_st     <= S_ROUND;
            r_in_rdy <= 1'b0;
          end
        end
        S_ROUND: begin
          r_state <= w_rnd_out;
          r_key   <= w_nk;
          r_rcon  <= xtime(r_rcon);
          if (w_final) begin
            r_st      <= S_DONE;
            r_out_vld <= 1'b1;
          end else begin
            r_rnd <= r_rnd + 4'd1;
          end
        end
        S_DONE: begin
          if (OUT_ready) begin
            r_st      <= S_IDLE;
            r_out_vld <= 1'b0;
            r_in_rdy  <= 1'b1;
          end
        end
        default: begin
          r_st      <= S_IDLE;
          r_in_rdy  <= 1'b1;
          r_out_vld <= 1'b0;
        end
      endcase
    end
  end

  assign IN_ready  = r_in_rdy;
  assign OUT_valid = r_out_vld;
  assign OUT_data  = r_state;
  assign OUT_round = r_rnd;

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// Self-checking bench for aes128_round_ctrl: FIPS-197 vectors,
// backpressure, busy-input, mid-run reset and random blocks vs a model.
module tb_aes128_round_ctrl;

  logic         CLK;
  logic         RST;
  logic         IN_valid;
  logic         IN_ready;
  logic [127:0] IN_data;
  logic [127:0] IN_key;
  logic         OUT_valid;
  logic         OUT_ready;
  logic [127:0] OUT_data;
  logic [3:0]   OUT_round;

  int checks = 0;
  int errors = 0;

  logic [7:0] sb_tab [256];
  logic [7:0] rcon_m [11];

  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  aes128_round_ctrl dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_valid  (IN_valid),
    .IN_ready  (IN_ready),
    .IN_data   (IN_data),
    .IN_key    (IN_key),
    .OUT_valid (OUT_valid),
    .OUT_ready (OUT_ready),
    .OUT_data  (OUT_data),
    .OUT_round (OUT_round)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Carry-less product, then polynomial reduction by 0x11b.
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    logic [14:0] m;
    p = '0;
    m = 15'h011b;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--)
      if (p[i]) p = p ^ (m << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_tables();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] cst;
    cst = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8]
             ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cst[i];
      sb_tab[x] = s;
    end
    rcon_m[0] = 8'h00;
    rcon_m[1] = 8'h01;
    for (int i = 2; i <= 10; i++) rcon_m[i] = m_mul(rcon_m[i-1], 8'h02);
  endtask

  function automatic logic [127:0] m_aes(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0] s [16];
    logic [7:0] k [16];
    logic [7:0] t [16];
    logic [7:0] g [4];
    logic [7:0] rc;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      k[i] = key[127-8*i -: 8];
      s[i] = pt[127-8*i -: 8] ^ k[i];
    end
    rc = 8'h01;
    for (int rnd = 1; rnd <= 10; rnd++) begin
      g[0] = sb_tab[k[13]] ^ rc;
      g[1] = sb_tab[k[14]];
      g[2] = sb_tab[k[15]];
      g[3] = sb_tab[k[12]];
      for (int i = 0; i < 16; i++)
        k[i] = k[i] ^ ((i < 4) ? g[i] : k[i-4]);
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[r+4*c] = sb_tab[s[r+4*((c+r)%4)]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          if (rnd < 10)
            s[4*c+r] = m_mul(8'h02, t[4*c+r]) ^ m_mul(8'h03, t[4*c+(r+1)%4])
                     ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
          else
            s[4*c+r] = t[4*c+r];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
      rc = m_mul(rc, 8'h02);
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic run(input logic [127:0] pt, input logic [127:0] key,
                     input logic [127:0] exp, input int hold, input bit junk);
    int n;
    logic [127:0] d0;
    n = 0;
    while (!IN_ready && n < 40) begin tick(); n++; end
    chk("in_ready_wait", 128'(IN_ready), 128'(1));
    IN_valid = 1'b1;
    IN_data  = pt;
    IN_key   = key;
    tick();
    IN_valid = 1'b0;
    n = 1;
    while (!OUT_valid && n < 40) begin
      chk("busy_in_ready", 128'(IN_ready), 128'(0));
      if (n <= 10) chk("round_cnt", 128'(OUT_round), 128'(n));
      if (n >= 8 && n <= 10) chk("rcon", 128'(dut.r_rcon), 128'(rcon_m[n]));
      if (junk) begin
        IN_valid = 1'($urandom_range(0, 1));
        IN_data  = {$urandom, $urandom, $urandom, $urandom};
        IN_key   = {$urandom, $urandom, $urandom, $urandom};
      end
      tick();
      n++;
    end
    chk("latency", 128'(n), 128'(11));
    chk("out_data", OUT_data, exp);
    chk("out_round_done", 128'(OUT_round), 128'(10));
    chk("done_in_ready", 128'(IN_ready), 128'(0));
    d0 = OUT_data;
    for (int i = 0; i < hold; i++) begin
      if (junk) IN_valid = 1'($urandom_range(0, 1));
      tick();
      chk("hold_data", OUT_data, d0);
      chk("hold_valid", 128'(OUT_valid), 128'(1));
      chk("hold_in_ready", 128'(IN_ready), 128'(0));
    end
    IN_valid  = 1'b0;
    OUT_ready = 1'b1;
    tick();
    OUT_ready = 1'b0;
    chk("valid_drop", 128'(OUT_valid), 128'(0));
    chk("idle_in_ready", 128'(IN_ready), 128'(1));
  endtask

  initial begin
    logic [127:0] rp;
    logic [127:0] rk;
    RST       = 1'b1;
    IN_valid  = 1'b0;
    IN_data   = '0;
    IN_key    = '0;
    OUT_ready = 1'b0;
    build_tables();
    tick();
    tick();
    chk("rst_in_ready", 128'(IN_ready), 128'(1));
    chk("rst_out_valid", 128'(OUT_valid), 128'(0));
    chk("rst_out_data", OUT_data, 128'(0));
    chk("rst_out_round", 128'(OUT_round), 128'(0));
    chk("rst_rcon", 128'(dut.r_rcon), 128'(8'h01));
    RST = 1'b0;

    // OUT_ready while idle is ignored.
    OUT_ready = 1'b1;
    tick();
    tick();
    OUT_ready = 1'b0;
    chk("idle_ready_ign", 128'(OUT_valid), 128'(0));
    chk("idle_stay", 128'(IN_ready), 128'(1));

    run(B_PT, B_KEY, B_CT, 20, 1'b0);
    run(C_PT, C_KEY, C_CT, 0, 1'b0);
    run(B_PT, B_KEY, B_CT, 3, 1'b1);

    // Reset at c5, with IN_valid also high: reset wins.
    IN_valid = 1'b1;
    IN_data  = C_PT;
    IN_key   = C_KEY;
    tick();
    IN_valid = 1'b0;
    repeat (4) tick();
    chk("pre_rst_round", 128'(OUT_round), 128'(5));
    RST      = 1'b1;
    IN_valid = 1'b1;
    IN_data  = B_PT;
    IN_key   = B_KEY;
    tick();
    RST      = 1'b0;
    IN_valid = 1'b0;
    chk("mid_rst_in_ready", 128'(IN_ready), 128'(1));
    chk("mid_rst_out_valid", 128'(OUT_valid), 128'(0));
    chk("mid_rst_round", 128'(OUT_round), 128'(0));
    chk("mid_rst_data", OUT_data, 128'(0));
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("post_rst_no_valid", 128'(OUT_valid), 128'(0));
    end
    chk("post_rst_idle", 128'(IN_ready), 128'(1));
    run(C_PT, C_KEY, C_CT, 0, 1'b0);

    for (int j = 0; j < 6; j++) begin
      rp = {$urandom, $urandom, $urandom, $urandom};
      rk = {$urandom, $urandom, $urandom, $urandom};
      run(rp, rk, m_aes(rp, rk), int'($urandom_range(0, 4)), 1'(j % 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
